io_out_buffer: RTL
==================

IO_OUT_BUFFER -- requirements
Module: io_out_buffer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: byte width of the processor output port.
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 3: log2 of the FIFO depth (DEPTH = 2**DEPTH_LOG2 = 8 entries).
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 cpu_data  input  DATA_WIDTH  byte driven by the processor's out port.
REQ-006 cpu_ready  input  1  processor's outDataReady; high means cpu_data is valid.
REQ-007 cpu_ack  output  1  drives the processor's outACK.
REQ-008 flush  input  1  synchronous discard of all buffered bytes.
REQ-009 dev_data  output  DATA_WIDTH  head-of-FIFO byte for the external device.
REQ-010 dev_valid  output  1  high when dev_data holds a buffered byte.
REQ-011 dev_ready  input  1  device accepts dev_data this cycle.
REQ-012 count  output  DEPTH_LOG2+1  number of buffered bytes, 0..DEPTH.
REQ-013 full / empty  output  1 each  count==DEPTH / count==0.

Function
REQ-014 Capture side SHALL be a two-state FSM, IDLE and ACKING, implementing the processor's four-phase handshake.
REQ-015 IDLE: cpu_ready=1, full=0 and flush=0 at an edge -> write cpu_data at wr_ptr, increment wr_ptr, go to ACKING.
REQ-016 IDLE with cpu_ready=1 and full=1 -> stay in IDLE, no write, cpu_ack held 0 (back-pressure; no byte is ever dropped).
REQ-017 cpu_ack SHALL be registered: 1 while the FSM is in ACKING, 0 in IDLE; it rises the cycle after the write edge.
REQ-018 ACKING: stay while cpu_ready=1; on an edge with cpu_ready=0 -> IDLE, so cpu_ack falls one cycle after cpu_ready falls.
REQ-019 Exactly one FIFO write SHALL occur per cpu_ready rising handshake, regardless of how long cpu_ready stays high.
REQ-020 Read side SHALL be first-word-fall-through: dev_valid = !empty; dev_data = mem[rd_ptr] combinationally.
REQ-021 A pop SHALL occur on an edge with dev_valid=1, dev_ready=1 and flush=0: increment rd_ptr, count decrements.
REQ-022 A byte written into an empty FIFO SHALL appear on dev_data with dev_valid=1 in the cycle after the write edge (1-cycle latency).
REQ-023 Simultaneous push and pop: both take effect, count unchanged. When full, push is blocked by REQ-016 even if a pop occurs in the same cycle.
REQ-024 rd_ptr and wr_ptr are DEPTH_LOG2 bits wide and SHALL wrap modulo DEPTH. count SHALL be maintained separately and never exceed DEPTH or go below 0.
REQ-025 dev_ready with empty=1 SHALL have no effect.
REQ-026 flush=1 SHALL take priority over push and pop: at the edge, rd_ptr=wr_ptr=0, count=0.
REQ-027 Flush SHALL NOT alter the FSM state. A handshake in ACKING completes normally. A flush in IDLE blocks acceptance for that cycle only.
REQ-028 dev_data SHALL be unspecified while dev_valid=0.

Reset
REQ-029 On reset low, asynchronously and independent of clk: FSM=IDLE, cpu_ack=0, rd_ptr=wr_ptr=0, count=0, empty=1, full=0, dev_valid=0.
REQ-030 FIFO storage SHALL NOT be reset.
REQ-031 Reset asserted mid-handshake SHALL abandon it. After release with cpu_ready still 1, the block SHALL treat it as a new request and write cpu_data once.

Verification
REQ-032 Single byte: cpu_data=8'h5A, cpu_ready=1 -> cpu_ack=1 next cycle. Hold cpu_ready 3 more cycles, then drop it: cpu_ack=0 one cycle later, count=1, dev_data=8'h5A, dev_valid=1, exactly one write.
REQ-033 Fill and back-pressure: 8 handshakes 8'h00..8'h07 with dev_ready=0 -> full=1, count=8. A 9th cpu_ready=1 keeps cpu_ack=0. Then a single pop -> 9th byte accepted, count returns to 8.
REQ-034 Wrap order: 12 bytes 8'h10..8'h1B pushed while dev_ready toggles each cycle -> device receives 8'h10..8'h1B in order, no loss and no duplication across pointer wrap.
REQ-035 Simultaneous push/pop at count=3 -> count stays 3, head advances by one.
REQ-036 Flush at count=5 while the FSM is in ACKING -> count=0, empty=1 next cycle; cpu_ack stays 1 until cpu_ready falls; the next handshake writes normally.
REQ-037 Reset pulse (reset=0 for 1 cycle) at count=4 during ACKING -> cpu_ack=0, count=0, dev_valid=0 immediately, without a clock edge.

Source files
------------

// File: rtl/io_out_buffer.sv
// Output buffer between a processor's four-phase out port and an external device:
// a two-state capture FSM feeding a first-word-fall-through FIFO.
module io_out_buffer #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] cpu_data,
   input  logic                  cpu_ready,
   output logic                  cpu_ack,
   input  logic                  flush,
   output logic [DATA_WIDTH-1:0] dev_data,
   output logic                  dev_valid,
   input  logic                  dev_ready,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  full,
   output logic                  empty
);

   localparam logic [0:0]            ST_IDLE   = 1'b0;
   localparam logic [0:0]            ST_ACKING = 1'b1;
   localparam logic [DEPTH_LOG2-1:0] L_PTR_ONE = DEPTH_LOG2'(1);
   localparam logic [DEPTH_LOG2:0]   L_CNT_ONE = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2:0]   L_DEPTH   = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);

   logic [DATA_WIDTH-1:0] r_mem [2**DEPTH_LOG2];
   logic [0:0]            r_state;
   logic                  r_cpu_ack;
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;

   logic [0:0]            w_state_nxt;
   logic [DEPTH_LOG2:0]   w_count_nxt;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;

   assign w_full  = (r_count == L_DEPTH);
   assign w_empty = (r_count == {(DEPTH_LOG2+1){1'b0}});
   // Acceptance only from IDLE, so a long cpu_ready high produces a single write.
   assign w_push  = (r_state == ST_IDLE) && cpu_ready && !w_full && !flush;
   assign w_pop   = !w_empty && dev_ready && !flush;

   assign cpu_ack   = r_cpu_ack;
   assign dev_valid = !w_empty;
   assign dev_data  = r_mem[r_rd_ptr];
   assign count     = r_count;
   assign full      = w_full;
   assign empty     = w_empty;

   // Capture FSM next state; flush never changes state.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_push) w_state_nxt = ST_ACKING;
            else        w_state_nxt = ST_IDLE;
         end
         ST_ACKING: begin
            if (!cpu_ready) w_state_nxt = ST_IDLE;
            else            w_state_nxt = ST_ACKING;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Occupancy next value; flush wins over push and pop.
   always_comb begin
      w_count_nxt = r_count;
      if (flush) begin
         w_count_nxt = {(DEPTH_LOG2+1){1'b0}};
      end else begin
         case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + L_CNT_ONE;
            2'b01:   w_count_nxt = r_count - L_CNT_ONE;
            default: w_count_nxt = r_count;
         endcase
      end
   end

   // Control state, acknowledge and pointers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_cpu_ack <= 1'b0;
         r_wr_ptr  <= {DEPTH_LOG2{1'b0}};
         r_rd_ptr  <= {DEPTH_LOG2{1'b0}};
         r_count   <= {(DEPTH_LOG2+1){1'b0}};
      end else begin
         r_state   <= w_state_nxt;
         r_cpu_ack <= (w_state_nxt == ST_ACKING);
         r_count   <= w_count_nxt;
         if (flush) begin
            r_wr_ptr <= {DEPTH_LOG2{1'b0}};
            r_rd_ptr <= {DEPTH_LOG2{1'b0}};
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
         end
      end
   end

   // Storage array is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= cpu_data;
   end

endmodule
